// File: rtl/ws2801_strip_driver_pkg.sv
// Shared types and constants for the WS2801 strip driver.
package ws2801_pkg;

    localparam int RGB_BITS = 24;
    localparam int LATCH_US = 501;
    localparam int CLK_MHZ  = 50;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } drv_state_t;

endpackage

// File: rtl/ws2801_strip_driver_if.sv
// Pixel stream handshake: the frame buffer is the master, the strip driver the slave.
interface ws2801_strip_driver_if;
    import ws2801_pkg::*;

    rgb_t pix_data;
    logic pix_valid;
    logic pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ws2801_tick_gen.sv
// Half-period counter for CKO: restarts on load_i, ticks on the last cycle of each half-period.
module ws2801_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic tick_o
);
    localparam int              CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/ws2801_strip_driver.sv
// WS2801 strip transmitter: streams LEDS RGB words MSB-first onto SDO/CKO, then holds CKO low to latch.
// Build option WS2801_UNDERRUN_EN adds a sticky flag for long mid-frame pixel stalls.
module ws2801_strip_driver
    import ws2801_pkg::*;
#(
    parameter int LEDS         = 5,
    parameter int CLK_DIV      = 2,
    parameter int LATCH_CYCLES = LATCH_US * CLK_MHZ
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    ws2801_strip_driver_if.slave         pix,
    output logic                         SDO,
    output logic                         CKO,
    output logic                         busy,
    output logic                         done,
    output logic                         underrun
);
    localparam int               LED_W    = $clog2(LEDS + 1);
    localparam int               LAT_W    = $clog2(LATCH_CYCLES + 1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    drv_state_t       state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [4:0]       bit_q, bit_d;
    logic [RGB_BITS-1:0] shift_q, shift_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             post_rst_q, post_rst_d;
    logic             sdo_q, sdo_d, cko_q, cko_d, busy_q, busy_d, done_q, done_d;
    logic             div_load, div_tick;

    ws2801_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .load_i (div_load),
        .tick_o (div_tick)
    );

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        lat_d      = lat_q;
        post_rst_d = post_rst_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                led_d   = '0;
                bit_d   = '0;
            end
            LOAD: if (pix.pix_valid) begin
                shift_d = pix.pix_data;
                bit_d   = 5'(RGB_BITS - 1);
                state_d = SHIFT_LO;
            end
            SHIFT_LO: if (div_tick) state_d = SHIFT_HI;
            SHIFT_HI: if (div_tick) begin
                if (bit_q != '0) begin
                    shift_d = {shift_q[RGB_BITS-2:0], 1'b0};
                    bit_d   = bit_q - 1'b1;
                    state_d = SHIFT_LO;
                end else if (led_q < LED_LAST) begin
                    led_d   = led_q + 1'b1;
                    state_d = LOAD;
                end else begin
                    lat_d   = '0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d    = IDLE;
                    post_rst_d = 1'b0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the upcoming state.
        div_load = (state_d != state_q);
        cko_d    = (state_d == SHIFT_HI);
        sdo_d    = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? shift_d[RGB_BITS-1] : 1'b0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == LATCH) && (lat_d == LAT_LAST) && !post_rst_d;
    end

    // Reset lands in LATCH so a strip left mid-frame is flushed, without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LATCH;
            led_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            lat_q      <= '0;
            post_rst_q <= 1'b1;
            sdo_q      <= 1'b0;
            cko_q      <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            lat_q      <= lat_d;
            post_rst_q <= post_rst_d;
            sdo_q      <= sdo_d;
            cko_q      <= cko_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef WS2801_UNDERRUN_EN
    localparam int                 STALL_LIMIT = LATCH_CYCLES / 2;
    localparam int                 STALL_W     = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_LIMIT);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               underrun_q, underrun_d;

    always_comb begin
        stall_d    = '0;
        underrun_d = underrun_q;
        if (state_q == IDLE && start) begin
            underrun_d = 1'b0;
        end else if (state_q == LOAD && !pix.pix_valid && led_q != '0) begin
            stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
            if (stall_d == STALL_MAX) underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            stall_q    <= stall_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

    assign pix.pix_ready = (state_q == LOAD);
    assign SDO  = sdo_q;
    assign CKO  = cko_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_ws2801_strip_driver.sv
// Bench: three driver instances (1 LED, 3 LEDs, defaults) each feeding a behavioural WS2801 chain model.
module tb_ws2801_strip_driver;
    import ws2801_pkg::*;

    localparam int NL  [3] = '{1, 3, 5};
    localparam int LTH [3] = '{20, 20, 25000};
`ifdef WS2801_UNDERRUN_EN
    localparam logic EXP_UND = 1'b1;
`else
    localparam logic EXP_UND = 1'b0;
`endif

    typedef struct {
        int          k;
        logic [23:0] p0, p1, p2;
        int          stall;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic [2:0]  rst, st, vld;
    logic [23:0] dat [3];
    wire  [2:0]  sdo, cko, busy, done, und, rdy;

    int cyc = 0, checks = 0, failures = 0, cko_stall_bad = 0;
    int edges [3], done_cnt [3], done_cyc [3], xfers [3];
    int hi_run [3], hi_bad [3], sdo_bad [3], low_cnt [3];
    logic [2:0]  cko_prev = '0, hi_sdo = '0, last_bit = '0;
    bit          rx [3][$];
    logic [23:0] strip [3][5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2801_strip_driver_if pix0 ();
    ws2801_strip_driver_if pix1 ();
    ws2801_strip_driver_if pix2 ();
    assign pix0.pix_data = rgb_t'(dat[0]);
    assign pix1.pix_data = rgb_t'(dat[1]);
    assign pix2.pix_data = rgb_t'(dat[2]);
    assign pix0.pix_valid = vld[0];
    assign pix1.pix_valid = vld[1];
    assign pix2.pix_valid = vld[2];
    assign rdy[0] = pix0.pix_ready;
    assign rdy[1] = pix1.pix_ready;
    assign rdy[2] = pix2.pix_ready;

    ws2801_strip_driver #(.LEDS(1), .CLK_DIV(2), .LATCH_CYCLES(20)) u_one (
        .clk(clk), .reset(rst[0]), .start(st[0]), .pix(pix0), .SDO(sdo[0]), .CKO(cko[0]),
        .busy(busy[0]), .done(done[0]), .underrun(und[0]));
    ws2801_strip_driver #(.LEDS(3), .CLK_DIV(2), .LATCH_CYCLES(20)) u_three (
        .clk(clk), .reset(rst[1]), .start(st[1]), .pix(pix1), .SDO(sdo[1]), .CKO(cko[1]),
        .busy(busy[1]), .done(done[1]), .underrun(und[1]));
    ws2801_strip_driver u_dflt (
        .clk(clk), .reset(rst[2]), .start(st[2]), .pix(pix2), .SDO(sdo[2]), .CKO(cko[2]),
        .busy(busy[2]), .done(done[2]), .underrun(und[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL timeout waiting for %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Chain model: bits shift in on CKI rising edges, LED j owns bits 24j..24j+23, and
    // every LED latches once CKI has stayed low for the latch time.
    task automatic strip_latch(input int k);
        logic [23:0] w;
        for (int j = 0; j < NL[k]; j++) begin
            if (rx[k].size() >= 24 * (j + 1)) begin
                w = '0;
                for (int b = 0; b < 24; b++) w = {w[22:0], rx[k][24*j+b]};
                strip[k][j] = w;
            end
        end
        rx[k].delete();
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cko[k] === 1'b1) begin
                if (cko_prev[k] !== 1'b1) begin
                    rx[k].push_back(sdo[k]);
                    edges[k]++;
                    hi_sdo[k]   = sdo[k];
                    last_bit[k] = sdo[k];
                    hi_run[k]   = 0;
                    low_cnt[k]  = 0;
                end
                hi_run[k]++;
                if (sdo[k] !== hi_sdo[k]) sdo_bad[k]++;
            end else begin
                if (cko_prev[k] === 1'b1 && hi_run[k] != 2) hi_bad[k]++;
                low_cnt[k]++;
                if (low_cnt[k] == LTH[k]) strip_latch(k);
            end
            if (done[k] === 1'b1) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
            if (rdy[k] === 1'b1 && vld[k] === 1'b1) xfers[k]++;
            cko_prev[k] = cko[k];
        end
    end

    task automatic wait_idle(input int k);
        int g = 0;
        while (busy[k] !== 1'b0 && g < 30000) begin step(); g++; end
        if (busy[k] !== 1'b0) timeout("idle");
    endtask

    // Sends one frame; stl[i] idle LOAD cycles precede word i. lat = start cycle to done cycle.
    task automatic send_frame(input int k, input int n, input logic [23:0] px [5],
                              input int stl [5], output int lat);
        int t0, d0, g;
        lat = -1;
        wait_idle(k);
        d0 = done_cnt[k];
        st[k] = 1'b1;
        t0 = cyc;
        step();
        st[k] = 1'b0;
        check("ready_after_start", rdy[k], 1);
        for (int i = 0; i < n; i++) begin
            g = 0;
            while (rdy[k] !== 1'b1 && g < 200) begin step(); g++; end
            if (rdy[k] !== 1'b1) begin timeout("pix_ready"); return; end
            for (int s = 0; s < stl[i]; s++) begin
                if (cko[k] !== 1'b0) cko_stall_bad++;
                step();
            end
            vld[k] = 1'b1;
            dat[k] = px[i];
            step();
            vld[k] = 1'b0;
        end
        g = 0;
        while (done_cnt[k] == d0 && g < 30000) begin step(); g++; end
        if (done_cnt[k] == d0) begin timeout("done"); return; end
        lat = done_cyc[k] - t0;
        check("busy_after_done", busy[k], 0);
    endtask

    task automatic run_big();
        logic [23:0] px [5];
        int stl [5];
        int lat;
        stl = '{default: 0};
        wait_idle(2);
        check("big_post_reset_no_done", done_cnt[2], 0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) px[i] = (f == 0) ? 24'hFFFFFF : 24'hFFF000;
            send_frame(2, 5, px, stl, lat);
            check($sformatf("big%0d_latency", f), lat, 5 * (1 + 48 * 2) + 25050);
            for (int j = 0; j < 5; j++) check($sformatf("big%0d_led%0d", f, j), strip[2][j], px[j]);
            check("big_underrun", und[2], 0);
        end
    endtask

    task automatic run_small();
        logic [23:0] px [5];
        int stl [5];
        int lat, k, n, e0, x0, d0, g, sum, lc;
        bit p1, p2;
        vec_t tbl [4];
        tbl = '{'{0, 24'hA5C30F, 24'h0, 24'h0, 0, 117},
                '{0, 24'h800001, 24'h0, 24'h0, 0, 117},
                '{1, 24'hFFFFFF, 24'hF0F0F0, 24'h000001, 7, 318},
                '{1, 24'h123456, 24'hABCDEF, 24'hFEDCBA, 0, 311}};
        wait_idle(0);
        wait_idle(1);
        check("post_reset_no_done", done_cnt[0] + done_cnt[1], 0);

        for (int v = 0; v < 4; v++) begin
            k = tbl[v].k;
            n = NL[k];
            px  = '{tbl[v].p0, tbl[v].p1, tbl[v].p2, 24'h0, 24'h0};
            stl = '{0, tbl[v].stall, 0, 0, 0};
            e0 = edges[k]; x0 = xfers[k]; d0 = done_cnt[k];
            send_frame(k, n, px, stl, lat);
            check($sformatf("v%0d_latency", v), lat, tbl[v].exp_lat);
            check($sformatf("v%0d_edges", v), edges[k] - e0, 24 * n);
            check($sformatf("v%0d_transfers", v), xfers[k] - x0, n);
            check($sformatf("v%0d_dones", v), done_cnt[k] - d0, 1);
            check($sformatf("v%0d_last_bit", v), last_bit[k], px[n-1][0]);
            for (int j = 0; j < n; j++) check($sformatf("v%0d_led%0d", v, j), strip[k][j], px[j]);
            check($sformatf("v%0d_underrun", v), und[k], 0);
        end

        // Long stall before the second word trips the underrun threshold (LATCH_CYCLES/2 = 10).
        px  = '{24'h010203, 24'h040506, 24'h070809, 24'h0, 24'h0};
        stl = '{0, 10, 0, 0, 0};
        send_frame(1, 3, px, stl, lat);
        check("stall10_latency", lat, 3 * 97 + 10 + 20);
        check("stall10_underrun_after_done", und[1], EXP_UND);
        for (int j = 0; j < 3; j++) check($sformatf("stall10_led%0d", j), strip[1][j], px[j]);

        // Reset while shifting bit 10 of LED 1.
        wait_idle(1);
        d0 = done_cnt[1]; e0 = edges[1];
        st[1] = 1'b1; step(); st[1] = 1'b0;
        vld[1] = 1'b1; dat[1] = 24'h5A5A5A;
        g = 0;
        while (!(edges[1] == e0 + 34 && cko[1] === 1'b0) && g < 500) begin step(); g++; end
        if (g >= 500) timeout("bit 10 of LED 1");
        rst[1] = 1'b1; step(); rst[1] = 1'b0; vld[1] = 1'b0;
        check("rst_cko", cko[1], 0);
        check("rst_sdo", sdo[1], 0);
        check("rst_busy", busy[1], 1);
        check("rst_ready", rdy[1], 0);
        check("rst_underrun", und[1], 0);
        repeat (19) step();
        check("rst_busy_last_latch", busy[1], 1);
        step();
        check("rst_idle_after_latch", busy[1], 0);
        check("rst_no_done", done_cnt[1] - d0, 0);

        // Random frames, checked against the chain model and the frame-time formula.
        for (int r = 0; r < 4; r++) begin
            sum = 0;
            for (int i = 0; i < 5; i++) begin
                px[i]  = 24'($urandom);
                stl[i] = (i < 3) ? $urandom_range(0, 5) : 0;
                sum += stl[i];
            end
            send_frame(1, 3, px, stl, lat);
            check($sformatf("rnd%0d_latency", r), lat, 3 * (1 + 48 * 2) + sum + 20);
            for (int j = 0; j < 3; j++) check($sformatf("rnd%0d_led%0d", r, j), strip[1][j], px[j]);
            check($sformatf("rnd%0d_underrun", r), und[1], 0);
        end

        // start pulses during SHIFT_HI and during LATCH must be ignored.
        wait_idle(1);
        d0 = done_cnt[1]; e0 = edges[1];
        p1 = 1'b0; p2 = 1'b0; lc = 0;
        st[1] = 1'b1; step(); st[1] = 1'b0;
        vld[1] = 1'b1; dat[1] = 24'h0F0F0F;
        g = 0;
        while (done_cnt[1] == d0 && g < 500) begin
            st[1] = 1'b0;
            if (!p1 && cko[1] === 1'b1 && edges[1] == e0 + 5) begin
                st[1] = 1'b1; p1 = 1'b1;
            end else if (!p2 && edges[1] == e0 + 72 && cko[1] === 1'b0) begin
                lc++;
                if (lc == 5) begin st[1] = 1'b1; p2 = 1'b1; end
            end
            step();
            g++;
        end
        st[1] = 1'b0; vld[1] = 1'b0;
        if (done_cnt[1] == d0) timeout("done after ignored starts");
        check("ignored_start_pulses_sent", {p1, p2}, 2'b11);
        repeat (5) step();
        check("ignored_start_busy", busy[1], 0);
        check("ignored_start_dones", done_cnt[1] - d0, 1);
        check("ignored_start_edges", edges[1] - e0, 72);
    endtask

    initial begin
        rst = '1; st = '0; vld = '0;
        for (int k = 0; k < 3; k++) begin
            dat[k] = '0;
            for (int j = 0; j < 5; j++) strip[k][j] = '0;
        end
        step();
        step();
        rst = '0;
        check("reset_busy", busy, 3'b111);
        check("reset_cko", cko, 3'b000);
        check("reset_sdo", sdo, 3'b000);
        check("reset_done", done, 3'b000);
        check("reset_underrun", und, 3'b000);
        check("reset_ready", rdy, 3'b000);

        fork
            run_big();
            run_small();
        join

        check("cko_high_width", hi_bad[0] + hi_bad[1] + hi_bad[2], 0);
        check("sdo_stable_while_cko_high", sdo_bad[0] + sdo_bad[1] + sdo_bad[2], 0);
        check("cko_low_during_stall", cko_stall_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
